branch_target_predictor: RTL and testbench

Tagged, parametrised branch target buffer with per-entry saturating direction counters. Successor to the untagged valid+target BTB used by the pipeline front end. Looked up with the IF-stage PC and answers one cycle later in IG with hit, direction and next-PC. Trained from the resolve stage (WA). After reset, a sequential init engine clears all entries before the block reports ready.

---
 rtl/branch_target_predictor_if.sv | 27 ++
 rtl/branch_target_predictor.sv | 187 ++++++++++++++++++
 tb/tb_branch_target_predictor.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_predictor_if.sv
// Lookup (IF/IG) and training (WA) signals of the branch target predictor.
// master drives requests and training; slave is the predictor itself.
interface branch_target_predictor_if #(
  parameter int PC_W = 32
);
  logic            ready;
  logic            lk_en;
  logic [PC_W-1:0] lk_pc;
  logic            lk_hit;
  logic            lk_taken;
  logic [PC_W-1:0] lk_next;
  logic            up_en;
  logic [PC_W-1:0] up_pc;
  logic            up_branch;
  logic            up_taken;
  logic [PC_W-1:0] up_target;

  modport master (
    input  ready, lk_hit, lk_taken, lk_next,
    output lk_en, lk_pc, up_en, up_pc, up_branch, up_taken, up_target
  );

  modport slave (
    output ready, lk_hit, lk_taken, lk_next,
    input  lk_en, lk_pc, up_en, up_pc, up_branch, up_taken, up_target
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Tagged BTB with per-entry saturating direction counters.
// Lookup at IF answers one cycle later; training comes from the resolve stage.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | clearing valid bits, one index per cycle; updates ignored,
//           | lookups always miss
//   ST_RUN  | normal operation, ready=1
module branch_target_predictor #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 10,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_target_predictor_if.slave bus
);
  localparam int N = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             clr_we;
  logic             ready_q;

  logic             valid_q [N];
  logic [TAG_W-1:0] tag_mem [N];
  logic [PC_W-1:0]  tgt_mem [N];
  logic [CNT_W-1:0] cnt_mem [N];

  // Update-side decode
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             upd;
  logic [CNT_W-1:0] cnt_cur;

  // Single write port into the entry storage
  logic             v_we;
  logic [IDX_W-1:0] v_widx;
  logic             v_wdata;
  logic             e_we;
  logic [TAG_W-1:0] e_tag;
  logic [PC_W-1:0]  e_tgt;
  logic [CNT_W-1:0] e_cnt;

  // Lookup pipeline
  logic [IDX_W-1:0] lk_idx;
  logic [PC_W-1:0]  lk_pc_q;
  logic             rd_valid_q;
  logic [TAG_W-1:0] rd_tag_q;
  logic [PC_W-1:0]  rd_tgt_q;
  logic             rd_dir_q;
  logic             seen_q;
  logic             hit;
  logic             taken;

  // State register, clear pointer and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= (state_d == ST_RUN);
    end
  end

  // Next-state: walk every index once, then run
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d   = ST_INIT;
        clr_idx_d = '0;
      end
    endcase
  end

  assign up_idx  = bus.up_pc[2 +: IDX_W];
  assign up_tag  = bus.up_pc[2+IDX_W +: TAG_W];
  assign up_hit  = valid_q[up_idx] && (tag_mem[up_idx] == up_tag);
  assign upd     = (state_q == ST_RUN) && bus.up_en;
  assign cnt_cur = cnt_mem[up_idx];

  // Training decision: counter step, allocation or stale-alias invalidation
  always_comb begin
    v_we    = 1'b0;
    v_widx  = up_idx;
    v_wdata = 1'b0;
    e_we    = 1'b0;
    e_tag   = up_tag;
    e_tgt   = tgt_mem[up_idx];
    e_cnt   = cnt_cur;
    if (clr_we) begin
      v_we    = 1'b1;
      v_widx  = clr_idx_q;
      v_wdata = 1'b0;
    end else if (upd && bus.up_branch) begin
      if (up_hit) begin
        e_we = 1'b1;
        if (bus.up_taken) begin
          e_tgt = bus.up_target;
          e_cnt = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_W'(1);
        end else begin
          e_cnt = (cnt_cur == '0) ? cnt_cur : cnt_cur - CNT_W'(1);
        end
      end else if (bus.up_taken) begin
        v_we    = 1'b1;
        v_wdata = 1'b1;
        e_we    = 1'b1;
        e_tgt   = bus.up_target;
        e_cnt   = CNT_WEAK;
      end
    end else if (upd && up_hit) begin
      v_we    = 1'b1;
      v_wdata = 1'b0;
    end
  end

  // Valid bits live in flops so INIT can clear them one per cycle
  always_ff @(posedge clk) begin
    if (v_we) valid_q[v_widx] <= v_wdata;
  end

  // Entry payload storage, written only by training
  always_ff @(posedge clk) begin
    if (e_we) begin
      tag_mem[up_idx] <= e_tag;
      tgt_mem[up_idx] <= e_tgt;
      cnt_mem[up_idx] <= e_cnt;
    end
  end

  assign lk_idx = bus.lk_pc[2 +: IDX_W];

  // Registered read of the payload; holds when no lookup is issued
  always_ff @(posedge clk) begin
    if (bus.lk_en) begin
      rd_tag_q <= tag_mem[lk_idx];
      rd_tgt_q <= tgt_mem[lk_idx];
      rd_dir_q <= cnt_mem[lk_idx][CNT_W-1];
    end
  end

  // Lookup context; valid is masked while clearing so INIT lookups miss
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_pc_q    <= '0;
      rd_valid_q <= 1'b0;
      seen_q     <= 1'b0;
    end else if (bus.lk_en) begin
      lk_pc_q    <= bus.lk_pc;
      rd_valid_q <= (state_q == ST_RUN) && valid_q[lk_idx];
      seen_q     <= 1'b1;
    end
  end

  // seen_q keeps lk_next at zero until the first lookup after reset
  assign hit   = rd_valid_q && (rd_tag_q == lk_pc_q[2+IDX_W +: TAG_W]);
  assign taken = hit && rd_dir_q;

  assign bus.ready    = ready_q;
  assign bus.lk_hit   = hit;
  assign bus.lk_taken = taken;
  assign bus.lk_next  = !seen_q ? '0 : (taken ? rd_tgt_q : lk_pc_q + PC_W'(4));
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed and randomized checks of the branch target predictor against a
// table model of the BTB kept in the bench.
module tb_branch_target_predictor;
  localparam int PC_W  = 32;
  localparam int IDX_W = 10;
  localparam int TAG_W = 8;
  localparam int CNT_W = 2;
  localparam int N     = 1 << IDX_W;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int CWEAK = 1 << (CNT_W - 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_target_predictor_if #(.PC_W(PC_W)) bus();

  branch_target_predictor #(
    .PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_cnt   [N];
  bit          m_run;

  logic        exp_hit;
  logic        exp_taken;
  logic [31:0] exp_next;

  function automatic int unsigned f_idx(input logic [31:0] pc);
    return (pc / 4) % N;
  endfunction

  function automatic int unsigned f_tag(input logic [31:0] pc);
    return (pc / (4 * N)) % (1 << TAG_W);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.lk_en     = 1'b0;
    bus.lk_pc     = '0;
    bus.up_en     = 1'b0;
    bus.up_pc     = '0;
    bus.up_branch = 1'b0;
    bus.up_taken  = 1'b0;
    bus.up_target = '0;
  endtask

  task automatic model_update(input logic [31:0] pc, input bit br, input bit tk,
                              input logic [31:0] tgt);
    int unsigned i;
    bit h;
    i = f_idx(pc);
    h = m_valid[i] && (m_tag[i] == f_tag(pc));
    if (br) begin
      if (h) begin
        if (tk) begin
          m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
          m_tgt[i] = tgt;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (tk) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = f_tag(pc);
        m_tgt[i]   = tgt;
        m_cnt[i]   = CWEAK;
      end
    end else if (h) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // One cycle: drive at negedge, model reads before writing, compare next negedge
  task automatic step(input string name, input bit le, input logic [31:0] lpc,
                      input bit ue, input logic [31:0] upc, input bit br,
                      input bit tk, input logic [31:0] tgt);
    int unsigned i;
    bus.lk_en     = le;
    bus.lk_pc     = lpc;
    bus.up_en     = ue;
    bus.up_pc     = upc;
    bus.up_branch = br;
    bus.up_taken  = tk;
    bus.up_target = tgt;
    if (le) begin
      i = f_idx(lpc);
      if (m_run && m_valid[i] && (m_tag[i] == f_tag(lpc))) begin
        exp_hit   = 1'b1;
        exp_taken = (m_cnt[i] >= CWEAK);
        exp_next  = exp_taken ? m_tgt[i] : lpc + 32'd4;
      end else begin
        exp_hit   = 1'b0;
        exp_taken = 1'b0;
        exp_next  = lpc + 32'd4;
      end
    end
    if (ue && m_run) model_update(upc, br, tk, tgt);
    @(posedge clk);
    @(negedge clk);
    check({name, "_hit"},   32'(bus.lk_hit),   32'(exp_hit));
    check({name, "_taken"}, 32'(bus.lk_taken), 32'(exp_taken));
    check({name, "_next"},  bus.lk_next,       exp_next);
  endtask

  task automatic do_reset(input string name);
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_run = 1'b0;
    for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
    exp_hit   = 1'b0;
    exp_taken = 1'b0;
    exp_next  = '0;
    check({name, "_ready"}, 32'(bus.ready),    32'd0);
    check({name, "_hit"},   32'(bus.lk_hit),   32'd0);
    check({name, "_taken"}, 32'(bus.lk_taken), 32'd0);
    check({name, "_next"},  bus.lk_next,       32'd0);
  endtask

  // Counts not-ready cycles; poke drives lookups/updates that INIT must ignore
  task automatic wait_ready(input string name, input bit poke);
    int cnt;
    cnt = 0;
    while (!bus.ready && cnt < 3000) begin
      if (poke) begin
        bus.lk_en     = 1'b1;
        bus.lk_pc     = 32'h40;
        bus.up_en     = 1'b1;
        bus.up_pc     = 32'h40;
        bus.up_branch = 1'b1;
        bus.up_taken  = 1'b1;
        bus.up_target = 32'h300;
      end
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    idle();
    check({name, "_init_len"}, 32'(cnt), 32'd1024);
    if (poke) begin
      exp_hit   = 1'b0;
      exp_taken = 1'b0;
      exp_next  = 32'h44;
      check({name, "_init_lk_hit"},  32'(bus.lk_hit), 32'd0);
      check({name, "_init_lk_next"}, bus.lk_next,     32'h44);
    end
    m_run = 1'b1;
  endtask

  initial begin
    logic [31:0] pc_a, pc_b, tgt;
    bit ue, br, tk, le;

    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // 1: reset clear and first lookup
    do_reset("rst1");
    wait_ready("rst1", 1'b0);
    step("t1_lk", 1, 32'h40, 0, 0, 0, 0, 0);
    check("t1_next_const", bus.lk_next, 32'h44);

    // 2: allocate, hold with lk_en=0, not-taken miss does not allocate
    step("t2_alloc", 0, 0, 1, 32'h40, 1, 1, 32'h100);
    step("t2_lk", 1, 32'h40, 0, 0, 0, 0, 0);
    check("t2_next_const", bus.lk_next, 32'h100);
    step("t2_hold", 0, 32'h80, 0, 0, 0, 0, 0);
    step("t2_nt_miss", 0, 0, 1, 32'h80, 1, 0, 32'h999);
    step("t2_lk80", 1, 32'h80, 0, 0, 0, 0, 0);

    // 3: hysteresis
    step("t3_nt1", 0, 0, 1, 32'h40, 1, 0, 0);
    step("t3_lk1", 1, 32'h40, 0, 0, 0, 0, 0);
    check("t3_next_const", bus.lk_next, 32'h44);
    step("t3_nt2", 0, 0, 1, 32'h40, 1, 0, 0);
    step("t3_lk2", 1, 32'h40, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step("t3_tk", 0, 0, 1, 32'h40, 1, 1, 32'h100);
    step("t3_lk3", 1, 32'h40, 0, 0, 0, 0, 0);
    step("t3_nt3", 0, 0, 1, 32'h40, 1, 0, 0);
    step("t3_lk4", 1, 32'h40, 0, 0, 0, 0, 0);
    check("t3_taken_const", 32'(bus.lk_taken), 32'd1);

    // 4: tag alias replaces the entry
    step("t4_lk_alias", 1, 32'h1040, 0, 0, 0, 0, 0);
    step("t4_alloc", 0, 0, 1, 32'h1040, 1, 1, 32'h200);
    step("t4_lk_new", 1, 32'h1040, 0, 0, 0, 0, 0);
    check("t4_next_const", bus.lk_next, 32'h200);
    step("t4_lk_old", 1, 32'h40, 0, 0, 0, 0, 0);

    // 5: read-first same-cycle, then stale-alias invalidation
    step("t5_same", 1, 32'h40, 1, 32'h40, 1, 1, 32'h180);
    check("t5_same_const", 32'(bus.lk_hit), 32'd0);
    step("t5_after", 1, 32'h40, 0, 0, 0, 0, 0);
    step("t5_inval", 0, 0, 1, 32'h40, 0, 0, 0);
    step("t5_lk_inval", 1, 32'h40, 0, 0, 0, 0, 0);

    // randomized traffic over a few indices and tags with noisy upper bits
    for (int n = 0; n < 400; n++) begin
      pc_a = {12'($urandom_range(0, 4095)), 8'($urandom_range(0, 2)),
              10'($urandom_range(0, 3)), 2'b00};
      pc_b = {12'($urandom_range(0, 4095)), 8'($urandom_range(0, 2)),
              10'($urandom_range(0, 3)), 2'b00};
      tgt  = $urandom & 32'hFFFF_FFFC;
      le   = ($urandom_range(0, 3) != 0);
      ue   = ($urandom_range(0, 2) != 0);
      br   = ($urandom_range(0, 3) != 0);
      tk   = $urandom_range(0, 1) != 0;
      step("rnd", le, pc_a, ue, pc_b, br, tk, tgt);
    end

    // 6: reset mid-INIT, updates during INIT ignored, wrap-around
    do_reset("rst2");
    repeat (500) @(posedge clk);
    @(negedge clk);
    check("mid_init_ready", 32'(bus.ready), 32'd0);
    do_reset("rst3");
    wait_ready("rst3", 1'b1);
    step("t6_lk", 1, 32'h40, 0, 0, 0, 0, 0);
    check("t6_hit_const", 32'(bus.lk_hit), 32'd0);
    step("t6_wrap", 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    check("t6_wrap_const", bus.lk_next, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
